ram167_cfg_ctrl: RTL and testbench

Single-clock configuration controller for the 167-bit × 16-entry lookup RAM. It sits between the 32-bit control-register path and the RAM's update/readback port (the axi side). It assembles 167-bit entries from 32-bit word loads and commits them with a single write pulse. It also reads entries back and returns them to the host as a serialized 6-word response stream.

---
 rtl/ram167_cfg_ctrl.sv | 130 +++++++++++++
 tb/tb_ram167_cfg_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram167_cfg_ctrl.sv
// rtl/ram167_cfg_ctrl.sv - Config controller: staged 167-bit entry writes and 6-word readback stream.
module ram167_cfg_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 167
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              wdata_valid,
    input  logic [2:0]        wdata_idx,
    input  logic [31:0]       wdata,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_last,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt
);
    localparam int TOP_W = DATA_W - 160;

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_CAP, SEND} state_t;

    state_t            state;
    logic [DATA_W-1:0] staging;
    logic [DATA_W-1:0] rsp_buf;
    logic [2:0]        cnt;

    assign ram_data_in = staging;
    assign rsp_last    = rsp_valid && (cnt == 3'd5);

    // Word 5 only carries the top TOP_W bits of the entry; it is zero-extended.
    always_comb begin
        rsp_data = '0;
        if (rsp_valid) begin
            for (int k = 0; k < 5; k++) begin
                if (cnt == k[2:0]) rsp_data = rsp_buf[32*k +: 32];
            end
            if (cnt == 3'd5) rsp_data[TOP_W-1:0] = rsp_buf[DATA_W-1:160];
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state       <= IDLE;
            staging     <= '0;
            rsp_buf     <= '0;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            // Staging loads are independent of the FSM, so a load in the
            // acceptance cycle lands before the WR cycle presents the data.
            if (wdata_valid) begin
                case (wdata_idx)
                    3'd0: staging[31:0]    <= wdata;
                    3'd1: staging[63:32]   <= wdata;
                    3'd2: staging[95:64]   <= wdata;
                    3'd3: staging[127:96]  <= wdata;
                    3'd4: staging[159:128] <= wdata;
                    3'd5: staging[DATA_W-1:160] <= wdata[TOP_W-1:0];
                    default: ;
                endcase
            end

            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_rd_addr <= '0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_op) begin
                            state       <= RD_REQ;
                            ram_rd_en   <= 1'b1;
                            ram_rd_addr <= cmd_addr;
                        end else begin
                            state       <= WR;
                            ram_wr_en   <= 1'b1;
                            ram_wr_addr <= cmd_addr;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    stat_wr_cnt <= stat_wr_cnt + 16'd1;
                    cmd_ready   <= 1'b1;
                    state       <= IDLE;
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: begin
                    rsp_buf   <= ram_data_out;
                    cnt       <= '0;
                    rsp_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (rsp_ready) begin
                        if (cnt == 3'd5) begin
                            rsp_valid   <= 1'b0;
                            stat_rd_cnt <= stat_rd_cnt + 16'd1;
                            cmd_ready   <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram167_cfg_ctrl.sv
// tb/tb_ram167_cfg_ctrl.sv - Directed self-checking bench for ram167_cfg_ctrl.
module tb_ram167_cfg_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         wdata_valid;
    logic [2:0]   wdata_idx;
    logic [31:0]  wdata;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_op;
    logic [3:0]   cmd_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic         rsp_last;
    logic         ram_wr_en;
    logic [3:0]   ram_wr_addr;
    logic [166:0] ram_data_in;
    logic         ram_rd_en;
    logic [3:0]   ram_rd_addr;
    logic [166:0] ram_data_out;
    logic [15:0]  stat_wr_cnt;
    logic [15:0]  stat_rd_cnt;

    int errors = 0;
    int checks = 0;

    logic [166:0] mem [16];
    logic [166:0] exp_a;
    logic [166:0] exp_b;
    logic [166:0] exp_c;

    always #5 clk = ~clk;

    ram167_cfg_ctrl #(.ADDR_W(4), .DATA_W(167)) dut (
        .axi_clk(clk), .axi_rst(rst),
        .wdata_valid(wdata_valid), .wdata_idx(wdata_idx), .wdata(wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out),
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
    );

    // Behavioural RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
        if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [166:0] obs, input logic [166:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wsel(input logic [166:0] v, input int w);
        if (w < 5) return v[32*w +: 32];
        return {25'd0, v[166:160]};
    endfunction

    task automatic load(input logic [2:0] i, input logic [31:0] d);
        wdata_valid = 1'b1;
        wdata_idx   = i;
        wdata       = d;
        step();
        wdata_valid = 1'b0;
    endtask

    // Read entry a; holds rsp_ready low for stall_n cycles when word stall_w is shown.
    task automatic rd(input logic [3:0] a, input logic [166:0] expv, input int stall_w, input int stall_n);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = a; rsp_ready = 1'b1;
        chk("rd_accept_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("rd_en_t1", ram_rd_en, 1);
        chk("rd_addr_t1", ram_rd_addr, a);
        chk("rd_busy_t1", cmd_ready, 0);
        step();
        chk("rd_en_t2", ram_rd_en, 0);
        chk("rsp_valid_t2", rsp_valid, 0);
        for (int w = 0; w < 6; w++) begin
            step();
            if (w == stall_w) begin
                for (int s = 0; s < stall_n; s++) begin
                    rsp_ready = 1'b0;
                    chk("stall_valid", rsp_valid, 1);
                    chk("stall_data", rsp_data, wsel(expv, w));
                    chk("stall_last", rsp_last, 0);
                    step();
                end
            end
            rsp_ready = 1'b1;
            chk("rsp_valid", rsp_valid, 1);
            chk($sformatf("rsp_data_w%0d", w), rsp_data, wsel(expv, w));
            chk("rsp_last", rsp_last, (w == 5) ? 1 : 0);
        end
        step();
        chk("rd_done_ready", cmd_ready, 1);
        chk("rd_done_valid", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        ram_data_out = '0;
        rst = 1'b1; wdata_valid = 0; wdata_idx = 0; wdata = 0;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; rsp_ready = 0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_data_in", ram_data_in, 0);
        rst = 1'b0;
        step();
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_wr_en", ram_wr_en, 0);
        chk("rel_rd_en", ram_rd_en, 0);
        chk("rel_rsp_valid", rsp_valid, 0);
        chk("rel_rsp_data", rsp_data, 0);
        chk("rel_rsp_last", rsp_last, 0);
        chk("rel_wr_cnt", stat_wr_cnt, 0);
        chk("rel_rd_cnt", stat_rd_cnt, 0);

        // Staged write to address 3
        exp_a = {7'h7F, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        load(3'd0, 32'h11111111);
        load(3'd1, 32'h22222222);
        load(3'd2, 32'h33333333);
        load(3'd3, 32'h44444444);
        load(3'd4, 32'h55555555);
        load(3'd5, 32'hFFFFFF7F);
        load(3'd6, 32'h0BADF00D);
        chk("staging_full", ram_data_in, exp_a);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 4'd3;
        chk("wr_accept_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("wr_en_t1", ram_wr_en, 1);
        chk("wr_addr_t1", ram_wr_addr, 3);
        chk("wr_data_t1", ram_data_in, exp_a);
        chk("wr_busy_t1", cmd_ready, 0);
        step();
        chk("wr_en_t2", ram_wr_en, 0);
        chk("wr_ready_t2", cmd_ready, 1);
        chk("wr_cnt_1", stat_wr_cnt, 1);

        rd(4'd3, exp_a, 9, 0);
        chk("rd_cnt_1", stat_rd_cnt, 1);

        rd(4'd3, exp_a, 2, 4);
        chk("rd_cnt_2", stat_rd_cnt, 2);

        // Load in the acceptance cycle is committed; load during WR is not
        exp_b = {exp_a[166:32], 32'hDEADBEEF};
        exp_c = {exp_a[166:32], 32'hCAFEF00D};
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 4'd5;
        wdata_valid = 1'b1; wdata_idx = 3'd0; wdata = 32'hDEADBEEF;
        step();
        cmd_valid = 1'b0;
        wdata = 32'hCAFEF00D;
        chk("same_wr_en", ram_wr_en, 1);
        chk("same_wr_addr", ram_wr_addr, 5);
        chk("same_wr_data", ram_data_in, exp_b);
        step();
        wdata_idx = 3'd6; wdata = 32'h12345678;
        chk("post_wr_staging", ram_data_in, exp_c);
        chk("wr_cnt_2", stat_wr_cnt, 2);
        step();
        wdata_valid = 1'b0;
        chk("idx6_ignored", ram_data_in, exp_c);
        rd(4'd5, exp_b, 9, 0);
        chk("read_keeps_staging", ram_data_in, exp_c);

        // Reset during RD_REQ drops ram_rd_en asynchronously
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 4'd3;
        step();
        cmd_valid = 1'b0;
        chk("abort_rd_en_before", ram_rd_en, 1);
        rst = 1'b1;
        #1;
        chk("abort_rd_en", ram_rd_en, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        step();
        chk("abort_rel_ready", cmd_ready, 1);
        chk("abort_rd_cnt", stat_rd_cnt, 0);

        // Reset in SEND after word 1 has been handed over
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 4'd3; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        chk("send_w1", rsp_data, 32'h22222222);
        step();
        chk("send_w2_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("send_abort_valid", rsp_valid, 0);
        chk("send_abort_data", rsp_data, 0);
        chk("send_abort_last", rsp_last, 0);
        chk("send_abort_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_abort_valid", rsp_valid, 0);
        end
        chk("post_abort_rd_cnt", stat_rd_cnt, 0);
        chk("post_abort_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
